// File: rtl/lt24_oci_pkg.sv
// Shared definitions for the OCI debug RAM arbiter: FSM states, grant and
// command encodings, and the bit layout of the JTAG data word.
package lt24_oci_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int OCI_DATA_W = 32;
    localparam int JDO_W      = 38;

    localparam int JDO_WDATA_LSB     = 3;
    localparam int JDO_ADDR_LSB      = 17;
    localparam int JDO_RD_AFTER_LOAD = 34;
    localparam int JDO_CLR_OVR       = 35;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_J_RD  = 3'd1,
        ST_J_CAP = 3'd2,
        ST_J_WR  = 3'd3,
        ST_A_RD  = 3'd4,
        ST_A_CAP = 3'd5,
        ST_A_WR  = 3'd6,
        ST_A_ACK = 3'd7
    } oci_state_t;

    typedef enum logic {
        GRANT_AV = 1'b0,
        GRANT_J  = 1'b1
    } grant_t;

    typedef enum logic {
        JCMD_RD = 1'b0,
        JCMD_WR = 1'b1
    } jcmd_t;

    function automatic logic is_jtag_state(input oci_state_t s);
        return (s == ST_J_RD) || (s == ST_J_CAP) || (s == ST_J_WR);
    endfunction

endpackage

// File: rtl/lt24_oci_jtag_cmd_latch.sv
// Single-entry JTAG command register: holds the pending read/write, the
// auto-incrementing JTAG address, write data and the sticky overrun flag.
module lt24_oci_jtag_cmd_latch
    import lt24_oci_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              cmd_done,
    output logic [ADDR_W-1:0] jaddr,
    output logic              jpend,
    output logic              jpend_next,
    output jcmd_t             jcmd,
    output logic [DATA_W-1:0] jwdata,
    output logic              overrun
);

    logic [ADDR_W-1:0] jaddr_reg, jaddr_next;
    logic              jpend_reg;
    jcmd_t             jcmd_reg, jcmd_next;
    logic [DATA_W-1:0] jwdata_reg, jwdata_next;
    logic              overrun_reg, overrun_next;
    logic              queue;

    always_comb begin
        queue = take_no_action_ocimem_a | take_action_ocimem_b
              | (take_action_ocimem_a & jdo[JDO_RD_AFTER_LOAD]);

        // An address load beats the post-command increment in the same cycle.
        jaddr_next = jaddr_reg;
        if (take_action_ocimem_a)
            jaddr_next = jdo[JDO_ADDR_LSB +: ADDR_W];
        else if (cmd_done)
            jaddr_next = jaddr_reg + ADDR_W'(1);

        // A new command beats completion of the old one.
        jpend_next = jpend_reg;
        jcmd_next  = jcmd_reg;
        if (queue) begin
            jpend_next = 1'b1;
            jcmd_next  = take_action_ocimem_b ? JCMD_WR : JCMD_RD;
        end else if (cmd_done) begin
            jpend_next = 1'b0;
        end

        jwdata_next = jwdata_reg;
        if (take_action_ocimem_b)
            jwdata_next = jdo[JDO_WDATA_LSB +: DATA_W];

        overrun_next = overrun_reg;
        if (take_action_ocimem_a && jdo[JDO_CLR_OVR])
            overrun_next = 1'b0;
        else if (queue && jpend_reg && !cmd_done)
            overrun_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jaddr_reg   <= '0;
            jpend_reg   <= 1'b0;
            jcmd_reg    <= JCMD_RD;
            jwdata_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            jaddr_reg   <= jaddr_next;
            jpend_reg   <= jpend_next;
            jcmd_reg    <= jcmd_next;
            jwdata_reg  <= jwdata_next;
            overrun_reg <= overrun_next;
        end
    end

    assign jaddr   = jaddr_reg;
    assign jpend   = jpend_reg;
    assign jcmd    = jcmd_reg;
    assign jwdata  = jwdata_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/lt24_oci_ram_arbiter.sv
// Arbitrates the single-port OCI debug RAM between JTAG commands and the CPU
// Avalon debug slave; every output comes straight from a register.
module lt24_oci_ram_arbiter
    import lt24_oci_pkg::*;
#(
    parameter int ADDR_W = OCI_ADDR_W,
    parameter int DATA_W = OCI_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wrdata,
    output logic [3:0]        ram_byteen,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rddata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    oci_state_t        state_reg, state_next;
    grant_t            last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0] jaddr;
    logic              jpend, jpend_next, cmd_done;
    jcmd_t             jcmd;
    logic [DATA_W-1:0] jwdata;

    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_wrdata_reg, ram_wrdata_next;
    logic [3:0]        ram_byteen_reg, ram_byteen_next;
    logic              ram_we_reg, ram_we_next;
    logic [DATA_W-1:0] av_readdata_reg, mon_dreg_reg;
    logic              av_waitrequest_reg, jtag_busy_reg;

    assign cmd_done = (state_reg == ST_J_CAP) || (state_reg == ST_J_WR);

    lt24_oci_jtag_cmd_latch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmd_latch (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cmd_done                (cmd_done),
        .jaddr                   (jaddr),
        .jpend                   (jpend),
        .jpend_next              (jpend_next),
        .jcmd                    (jcmd),
        .jwdata                  (jwdata),
        .overrun                 (jtag_overrun)
    );

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        unique case (state_reg)
            ST_IDLE: begin
                // JTAG wins unless Avalon is waiting and JTAG had the last turn.
                if (jpend && (!(av_read || av_write) || last_grant_reg == GRANT_AV)) begin
                    state_next      = (jcmd == JCMD_WR) ? ST_J_WR : ST_J_RD;
                    last_grant_next = GRANT_J;
                end else if (av_read) begin
                    state_next      = ST_A_RD;
                    last_grant_next = GRANT_AV;
                end else if (av_write) begin
                    state_next      = ST_A_WR;
                    last_grant_next = GRANT_AV;
                end
            end
            ST_J_RD:  state_next = ST_J_CAP;
            ST_J_CAP: state_next = ST_IDLE;
            ST_J_WR:  state_next = ST_IDLE;
            ST_A_RD:  state_next = ST_A_CAP;
            ST_A_CAP: state_next = ST_A_ACK;
            ST_A_WR:  state_next = ST_A_ACK;
            ST_A_ACK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // RAM port values are registered alongside the state they belong to.
        ram_addr_next   = '0;
        ram_wrdata_next = '0;
        ram_byteen_next = 4'h0;
        ram_we_next     = 1'b0;
        unique case (state_next)
            ST_J_RD: ram_addr_next = jaddr;
            ST_J_WR: begin
                ram_addr_next   = jaddr;
                ram_wrdata_next = jwdata;
                ram_byteen_next = 4'hF;
                ram_we_next     = 1'b1;
            end
            ST_A_RD: ram_addr_next = av_address;
            ST_A_WR: begin
                ram_addr_next   = av_address;
                ram_wrdata_next = av_writedata;
                ram_byteen_next = av_byteenable;
                ram_we_next     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            last_grant_reg     <= GRANT_AV;
            ram_addr_reg       <= '0;
            ram_wrdata_reg     <= '0;
            ram_byteen_reg     <= 4'h0;
            ram_we_reg         <= 1'b0;
            av_readdata_reg    <= '0;
            mon_dreg_reg       <= '0;
            av_waitrequest_reg <= 1'b1;
            jtag_busy_reg      <= 1'b0;
        end else begin
            state_reg          <= state_next;
            last_grant_reg     <= last_grant_next;
            ram_addr_reg       <= ram_addr_next;
            ram_wrdata_reg     <= ram_wrdata_next;
            ram_byteen_reg     <= ram_byteen_next;
            ram_we_reg         <= ram_we_next;
            av_waitrequest_reg <= (state_next != ST_A_ACK);
            jtag_busy_reg      <= jpend_next | is_jtag_state(state_next);
            if (state_reg == ST_A_CAP)
                av_readdata_reg <= ram_rddata;
            if (state_reg == ST_J_CAP)
                mon_dreg_reg <= ram_rddata;
        end
    end

    assign ram_addr       = ram_addr_reg;
    assign ram_wrdata     = ram_wrdata_reg;
    assign ram_byteen     = ram_byteen_reg;
    assign ram_we         = ram_we_reg;
    assign av_readdata    = av_readdata_reg;
    assign av_waitrequest = av_waitrequest_reg;
    assign MonDReg        = mon_dreg_reg;
    assign jtag_busy      = jtag_busy_reg;

endmodule

// File: tb/tb_lt24_oci_ram_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural 1-cycle-read RAM.
module tb_lt24_oci_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0;
    logic        take_no_action_ocimem_a = 1'b0;
    logic        take_action_ocimem_b = 1'b0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0;
    logic        av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wrdata;
    logic [3:0]  ram_byteen;
    logic        ram_we;
    logic [31:0] ram_rddata;
    logic [31:0] MonDReg;
    logic        jtag_busy;
    logic        jtag_overrun;

    logic [31:0] mem [256];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lt24_oci_ram_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wrdata              (ram_wrdata),
        .ram_byteen              (ram_byteen),
        .ram_we                  (ram_we),
        .ram_rddata              (ram_rddata),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun)
    );

    // Behavioural RAM: registered read, byte-enabled write, plus a backdoor for preload.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
        end
        ram_rddata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j = '0;
        j[17 +: 8] = a;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe_a(input logic [7:0] a, input logic rd, input logic clr);
        $display("txn jtag ocimem_a addr=%h rd=%0d clr=%0d", a, rd, clr);
        jdo = jdo_a(a, rd, clr); take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_na();
        $display("txn jtag no_action_ocimem_a");
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        $display("txn jtag ocimem_b wdata=%h", d);
        jdo = jdo_b(d); take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    logic grants [8];
    int   ng;
    int   wd;
    logic strobe_on;

    initial begin
        // Preload while reset holds the DUT idle.
        bd_write(8'h00, 32'hA0A0A0A0);
        bd_write(8'h10, 32'hDEADBEEF);
        bd_write(8'h11, 32'h11111111);
        bd_write(8'h20, 32'hCAFEF00D);
        bd_write(8'h30, 32'hFFFFFFFF);
        bd_write(8'h40, 32'h40404040);
        do_reset();

        // Reset values
        chk("rst_waitreq", 32'(av_waitrequest), 32'd1);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_busy", 32'(jtag_busy), 32'd0);
        chk("rst_overrun", 32'(jtag_overrun), 32'd0);
        chk("rst_readdata", av_readdata, 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);

        // JTAG load address 0x10 with read-after-load
        strobe_a(8'h10, 1'b1, 1'b0);
        chk("j1_busy_pend", 32'(jtag_busy), 32'd1);
        tick();
        chk("j1_rd_addr", 32'(ram_addr), 32'h10);
        chk("j1_rd_we", 32'(ram_we), 32'd0);
        tick();
        chk("j1_cap_mon_early", MonDReg, 32'h0);
        tick();
        chk("j1_mondreg", MonDReg, 32'hDEADBEEF);
        chk("j1_busy_done", 32'(jtag_busy), 32'd0);

        // Read at auto-incremented address 0x11
        strobe_na();
        tick();
        chk("j2_rd_addr", 32'(ram_addr), 32'h11);
        tick(2);
        chk("j2_mondreg", MonDReg, 32'h11111111);

        // Write at 0xFF, address wraps to 0x00
        strobe_a(8'hFF, 1'b0, 1'b0);
        chk("j3_load_only_busy", 32'(jtag_busy), 32'd0);
        strobe_b(32'h12345678);
        tick();
        chk("j3_we", 32'(ram_we), 32'd1);
        chk("j3_addr", 32'(ram_addr), 32'hFF);
        chk("j3_wrdata", ram_wrdata, 32'h12345678);
        chk("j3_byteen", 32'(ram_byteen), 32'hF);
        tick();
        chk("j3_mem_ff", mem[8'hFF], 32'h12345678);
        strobe_na();
        tick();
        chk("j4_wrap_addr", 32'(ram_addr), 32'h00);
        tick(2);
        chk("j4_mondreg", MonDReg, 32'hA0A0A0A0);

        // Avalon partial write
        $display("txn avalon write addr=30 data=aaaa5555 be=0011");
        av_address = 8'h30; av_writedata = 32'hAAAA5555; av_byteenable = 4'b0011; av_write = 1'b1;
        tick();
        chk("a1_we", 32'(ram_we), 32'd1);
        chk("a1_byteen", 32'(ram_byteen), 32'h3);
        chk("a1_addr", 32'(ram_addr), 32'h30);
        chk("a1_waitreq_c1", 32'(av_waitrequest), 32'd1);
        tick();
        chk("a1_waitreq_c2", 32'(av_waitrequest), 32'd0);
        av_write = 1'b0;
        tick();
        chk("a1_waitreq_c3", 32'(av_waitrequest), 32'd1);
        chk("a1_mem", mem[8'h30], 32'hFFFF5555);

        // Conflicts: JTAG writes vs continuous Avalon reads, round robin from reset
        do_reset();
        strobe_b(32'h5A5A0000);
        $display("txn avalon read stream addr=20 against jtag writes");
        av_address = 8'h20; av_read = 1'b1;
        ng = 0; wd = 1; strobe_on = 1'b0;
        for (int cyc = 0; cyc < 100 && ng < 8; cyc++) begin
            tick();
            if (strobe_on) begin
                take_action_ocimem_b = 1'b0;
                strobe_on = 1'b0;
            end
            if (ram_we) begin
                grants[ng] = 1'b1;
                ng++;
            end else if (!av_waitrequest) begin
                chk("rr_readdata", av_readdata, 32'hCAFEF00D);
                grants[ng] = 1'b0;
                ng++;
            end
            if (!jtag_busy && !strobe_on) begin
                jdo = jdo_b(32'h5A5A0000 + 32'(wd));
                take_action_ocimem_b = 1'b1;
                strobe_on = 1'b1;
                wd++;
            end
        end
        chk("rr_grant_count", 32'(ng), 32'd8);
        av_read = 1'b0;
        take_action_ocimem_b = 1'b0;
        tick(8);
        for (int k = 0; k < ng; k++)
            chk($sformatf("rr_grant%0d", k), 32'(grants[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_mem%0d", k), mem[k], 32'h5A5A0000 + 32'(k));

        // Overrun: two JTAG commands while Avalon holds the RAM
        do_reset();
        $display("txn avalon read addr=20 with jtag overrun");
        av_address = 8'h20; av_read = 1'b1;
        tick();
        strobe_a(8'h40, 1'b1, 1'b0);
        strobe_b(32'h77777777);
        chk("ov_waitreq", 32'(av_waitrequest), 32'd0);
        chk("ov_flag", 32'(jtag_overrun), 32'd1);
        chk("ov_busy", 32'(jtag_busy), 32'd1);
        av_read = 1'b0;
        tick(2);
        chk("ov_we", 32'(ram_we), 32'd1);
        chk("ov_addr", 32'(ram_addr), 32'h40);
        tick();
        chk("ov_mem", mem[8'h40], 32'h77777777);
        chk("ov_no_read", MonDReg, 32'h0);
        strobe_a(8'h00, 1'b0, 1'b1);
        chk("ov_cleared", 32'(jtag_overrun), 32'd0);

        // Reset during Avalon write and during JTAG capture
        $display("txn avalon write addr=50 interrupted by reset");
        av_address = 8'h50; av_writedata = 32'h11112222; av_byteenable = 4'hF; av_write = 1'b1;
        tick();
        chk("rw_we_before", 32'(ram_we), 32'd1);
        reset_n = 1'b0; av_write = 1'b0;
        tick();
        chk("rw_we", 32'(ram_we), 32'd0);
        chk("rw_waitreq", 32'(av_waitrequest), 32'd1);
        reset_n = 1'b1;
        tick();
        strobe_a(8'h10, 1'b1, 1'b0);
        tick(2);
        reset_n = 1'b0;
        tick();
        chk("rj_mondreg", MonDReg, 32'h0);
        chk("rj_busy", 32'(jtag_busy), 32'd0);
        chk("rj_waitreq", 32'(av_waitrequest), 32'd1);
        chk("rj_we", 32'(ram_we), 32'd0);
        reset_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
